// File: rtl/pll_lock_supervisor.sv
// Supervises a PLL from its reference-clock domain: drives the PLL reset pulse,
// filters the synchronized lock indication, retries on timeout and releases system reset.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 125000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       fault,
    output logic [7:0] lock_lost_cnt
);

    localparam int unsigned PW  = (RST_PULSE_CYCLES    > 1) ? $clog2(RST_PULSE_CYCLES)    : 1;
    localparam int unsigned FW  = (LOCK_FILTER_CYCLES  > 1) ? $clog2(LOCK_FILTER_CYCLES)  : 1;
    localparam int unsigned TW  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW  = (MAX_RETRIES         > 1) ? $clog2(MAX_RETRIES)         : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [FW-1:0] FILT_ONE   = FW'(1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_locked_s;
    logic [PW-1:0] r_pulse_cnt, w_pulse_nxt;
    logic [FW-1:0] r_filt_cnt,  w_filt_nxt;
    logic [TW-1:0] r_to_cnt,    w_to_nxt;
    logic [RW-1:0] r_retry_cnt, w_retry_nxt;
    logic [7:0]    r_lost_cnt,  w_lost_nxt;
    logic          r_pll_rst;
    logic          r_sys_rst_n;
    logic          r_pll_ready;
    logic          r_fault;
    logic          w_timeout;

    assign w_timeout = (r_to_cnt == TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = r_pulse_cnt;
        w_filt_nxt  = r_filt_cnt;
        w_to_nxt    = r_to_cnt;
        w_retry_nxt = r_retry_cnt;
        w_lost_nxt  = r_lost_cnt;
        unique case (r_state)
            ST_RESET_PLL: begin
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_pulse_nxt = '0;
                    w_to_nxt    = '0;
                end else begin
                    w_pulse_nxt = r_pulse_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                w_to_nxt = r_to_cnt + 1'b1;
                if (w_timeout) begin
                    w_to_nxt = '0;
                    if (r_retry_cnt == RETRY_LAST) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry_cnt + 1'b1;
                        w_state_nxt = ST_RESET_PLL;
                    end
                end else if (r_locked_s) begin
                    // The sample that leaves WAIT_LOCK is the first of the filter run,
                    // so the filter starts with one sample already counted.
                    if (LOCK_FILTER_CYCLES == 1) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = '0;
                    end else begin
                        w_state_nxt = ST_FILTER;
                        w_filt_nxt  = FILT_ONE;
                    end
                end
            end
            ST_FILTER: begin
                w_to_nxt = r_to_cnt + 1'b1;
                if (r_locked_s && (r_filt_cnt == FILT_LAST)) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = '0;
                end else if (w_timeout) begin
                    w_to_nxt = '0;
                    if (r_retry_cnt == RETRY_LAST) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry_cnt + 1'b1;
                        w_state_nxt = ST_RESET_PLL;
                    end
                end else if (!r_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else begin
                    w_filt_nxt = r_filt_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = ST_RESET_PLL;
                    w_pulse_nxt = '0;
                    if (r_lost_cnt != 8'hFF) begin
                        w_lost_nxt = r_lost_cnt + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_RESET_PLL;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_PLL;
            r_sync1     <= 1'b0;
            r_locked_s  <= 1'b0;
            r_pulse_cnt <= '0;
            r_filt_cnt  <= '0;
            r_to_cnt    <= '0;
            r_retry_cnt <= '0;
            r_lost_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ready <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_sync1     <= pll_locked;
            r_locked_s  <= r_sync1;
            r_state     <= w_state_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_filt_cnt  <= w_filt_nxt;
            r_to_cnt    <= w_to_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_lost_cnt  <= w_lost_nxt;
            // Outputs are decoded from the next state so they change on the transition edge.
            r_pll_rst   <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_pll_ready <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst_n     = r_sys_rst_n;
    assign pll_ready     = r_pll_ready;
    assign fault         = r_fault;
    assign lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small parameters
// (pulse 4, filter 8, timeout 64, retries 2).
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       fault;
    logic [7:0] lock_lost_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_FILTER_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(64),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .pll_ready    (pll_ready),
        .fault        (fault),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick;
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        total++; if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n); end
        total++; if (pll_ready !== 1'b0) begin bad++; $display("FAIL reset_pll_ready: got %b expected 0", pll_ready); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b expected 0", fault); end
        total++; if (lock_lost_cnt !== 8'd0) begin bad++; $display("FAIL reset_lost_cnt: got %0d expected 0", lock_lost_cnt); end
    endtask

    task automatic test_clean_lock;
        rst_n = 1'b0; pll_locked = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            total++;
            if (pll_rst !== 1'(i < 4)) begin bad++; $display("FAIL clean_pulse[%0d]: got %b expected %b", i, pll_rst, 1'(i < 4)); end
        end
        repeat (10) tick;
        pll_locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            total++;
            if (sys_rst_n !== 1'(i == 10)) begin bad++; $display("FAIL clean_sys_rst_n[%0d]: got %b expected %b", i, sys_rst_n, 1'(i == 10)); end
            total++;
            if (pll_ready !== 1'(i == 10)) begin bad++; $display("FAIL clean_ready[%0d]: got %b expected %b", i, pll_ready, 1'(i == 10)); end
        end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL clean_fault: got %b expected 0", fault); end
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL clean_pll_rst: got %b expected 0", pll_rst); end
    endtask

    task automatic test_glitchy_lock;
        rst_n = 1'b0; pll_locked = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (4) tick;
        pll_locked = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 6) pll_locked = 1'b0;
            tick;
            total++;
            if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL glitch_no_run[%0d]: got %b expected 0", i, sys_rst_n); end
            total++;
            if (pll_rst !== 1'b0) begin bad++; $display("FAIL glitch_pll_rst[%0d]: got %b expected 0", i, pll_rst); end
        end
        pll_locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            total++;
            if (sys_rst_n !== 1'(i == 10)) begin bad++; $display("FAIL glitch_run[%0d]: got %b expected %b", i, sys_rst_n, 1'(i == 10)); end
            total++;
            if (pll_rst !== 1'b0) begin bad++; $display("FAIL glitch_pll_rst2[%0d]: got %b expected 0", i, pll_rst); end
        end
    endtask

    task automatic test_lock_loss;
        pll_locked = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick;
            total++;
            if (sys_rst_n !== 1'(i < 3)) begin bad++; $display("FAIL loss_sys_rst_n[%0d]: got %b expected %b", i, sys_rst_n, 1'(i < 3)); end
            total++;
            if (pll_rst !== 1'(i >= 3 && i <= 6)) begin bad++; $display("FAIL loss_pll_rst[%0d]: got %b expected %b", i, pll_rst, 1'(i >= 3 && i <= 6)); end
        end
        total++; if (lock_lost_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt: got %0d expected 1", lock_lost_cnt); end
        pll_locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            total++;
            if (pll_ready !== 1'(i == 10)) begin bad++; $display("FAIL loss_relock[%0d]: got %b expected %b", i, pll_ready, 1'(i == 10)); end
        end
        total++; if (lock_lost_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt_after: got %0d expected 1", lock_lost_cnt); end
    endtask

    task automatic test_timeout_fault;
        logic exp_rst;
        rst_n = 1'b0; pll_locked = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        for (int i = 1; i <= 150; i++) begin
            tick;
            exp_rst = (i <= 3) || (i >= 68 && i <= 71) || (i >= 136);
            total++;
            if (pll_rst !== exp_rst) begin bad++; $display("FAIL to_pll_rst[%0d]: got %b expected %b", i, pll_rst, exp_rst); end
            total++;
            if (fault !== 1'(i >= 136)) begin bad++; $display("FAIL to_fault[%0d]: got %b expected %b", i, fault, 1'(i >= 136)); end
            total++;
            if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL to_sys_rst_n[%0d]: got %b expected 0", i, sys_rst_n); end
        end
        pll_locked = 1'b1;
        repeat (20) tick;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky: got %b expected 1", fault); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL fault_pll_rst: got %b expected 1", pll_rst); end
        total++; if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL fault_sys_rst_n: got %b expected 0", sys_rst_n); end
        total++; if (pll_ready !== 1'b0) begin bad++; $display("FAIL fault_ready: got %b expected 0", pll_ready); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b expected 0", fault); end
        tick;
        tick;
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            total++;
            if (sys_rst_n !== 1'(i == 12)) begin bad++; $display("FAIL fault_recover[%0d]: got %b expected %b", i, sys_rst_n, 1'(i == 12)); end
        end
    endtask

    task automatic test_saturation;
        for (int n = 1; n <= 260; n++) begin
            pll_locked = 1'b0;
            repeat (7) tick;
            pll_locked = 1'b1;
            repeat (10) tick;
            total++;
            if (sys_rst_n !== 1'b1) begin bad++; $display("FAIL sat_run[%0d]: got %b expected 1", n, sys_rst_n); end
            if (n == 254) begin
                total++;
                if (lock_lost_cnt !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d expected 254", lock_lost_cnt); end
            end
            if (n == 255) begin
                total++;
                if (lock_lost_cnt !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d expected 255", lock_lost_cnt); end
            end
        end
        total++; if (lock_lost_cnt !== 8'd255) begin bad++; $display("FAIL sat_final: got %0d expected 255", lock_lost_cnt); end
    endtask

    task automatic test_async_reset;
        rst_n = 1'b0; pll_locked = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (4) tick;
        pll_locked = 1'b1;
        repeat (5) tick;
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL async_pre_filter: got %b expected 0", pll_rst); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async_filter_pll_rst: got %b expected 1", pll_rst); end
        total++; if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL async_filter_sys_rst_n: got %b expected 0", sys_rst_n); end
        tick;
        rst_n = 1'b1;
        repeat (12) tick;
        pll_locked = 1'b0;
        repeat (7) tick;
        pll_locked = 1'b1;
        repeat (10) tick;
        total++; if (sys_rst_n !== 1'b1) begin bad++; $display("FAIL async_pre_run: got %b expected 1", sys_rst_n); end
        total++; if (lock_lost_cnt !== 8'd1) begin bad++; $display("FAIL async_pre_cnt: got %0d expected 1", lock_lost_cnt); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async_run_pll_rst: got %b expected 1", pll_rst); end
        total++; if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL async_run_sys_rst_n: got %b expected 0", sys_rst_n); end
        total++; if (pll_ready !== 1'b0) begin bad++; $display("FAIL async_run_ready: got %b expected 0", pll_ready); end
        total++; if (lock_lost_cnt !== 8'd0) begin bad++; $display("FAIL async_run_cnt: got %0d expected 0", lock_lost_cnt); end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        test_reset;
        test_clean_lock;
        test_glitchy_lock;
        test_lock_loss;
        test_timeout_fault;
        test_saturation;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
